// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - multi-cycle ripple adder, BITS_PER_CYCLE slices per clock
//
// Computes {cout, sum} = a + b + cin over N = WIDTH/BITS_PER_CYCLE cycles.
// Operands are captured on an accepted start, then consumed LSB-first by a
// chain of full-adder slices. The carry between cycles lives in a register.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request; honoured only in IDLE or DONE
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   busy   out  high while the addition runs
//   done   out  one-cycle pulse when sum/cout have just been updated
//   sum    out  WIDTH-bit registered result, held until next completion
//   cout   out  registered carry-out, held until next completion
//   ovf    out  two's-complement overflow (only with SERIAL_ADDER_OVF_EN)
//
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf output.

module serial_adder #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = (BITS_PER_CYCLE >= 1) ? (WIDTH / BITS_PER_CYCLE) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifndef SYNTHESIS
  initial begin
    if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin
      $error("serial_adder: illegal parameters WIDTH=%0d BITS_PER_CYCLE=%0d",
             WIDTH, BITS_PER_CYCLE);
      $finish;
    end
  end
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [WIDTH-1:0]          a_sh;
  logic [WIDTH-1:0]          b_sh;
  logic [WIDTH-1:0]          res_sh;
  logic                      carry;
  logic [CW-1:0]             cnt;

  logic [BITS_PER_CYCLE-1:0] slice_sum;
  logic                      slice_cout;
  logic                      slice_cin_msb;
  logic [WIDTH-1:0]          res_next;
  logic                      last;

  // Ripple across the slices for this cycle. slice_cin_msb is the carry into
  // the top slice; on the final cycle that is the carry into the word MSB.
  always_comb begin
    logic cc;
    cc            = carry;
    slice_sum     = '0;
    slice_cin_msb = 1'b0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      slice_cin_msb = cc;
      slice_sum[i]  = a_sh[i] ^ b_sh[i] ^ cc;
      cc            = (a_sh[i] & b_sh[i]) | (cc & (a_sh[i] ^ b_sh[i]));
    end
    slice_cout = cc;
  end

  // Slice result enters at the MSB end, so after N cycles the first slice
  // has reached bit 0. When BITS_PER_CYCLE == WIDTH the shift-out term is 0.
  assign res_next = (res_sh >> BITS_PER_CYCLE)
                  | (WIDTH'(slice_sum) << (WIDTH - BITS_PER_CYCLE));
  assign last     = (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            res_sh <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          a_sh   <= a_sh >> BITS_PER_CYCLE;
          b_sh   <= b_sh >> BITS_PER_CYCLE;
          res_sh <= res_next;
          carry  <= slice_cout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum   <= res_next;
            cout  <= slice_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= slice_cin_msb ^ slice_cout;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef SERIAL_ADDER_OVF_EN
  // Carry into the MSB only feeds the overflow output.
  logic unused_cin_msb;
  assign unused_cin_msb = slice_cin_msb;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus-only helpers: all tasks run from #1 after a rising edge.
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic c);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done4(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      errors++;
      $display("FAIL reset_u8: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
    checks++;
    if ({busy4, done4, sum4, cout4} !== 7'd0) begin
      errors++;
      $display("FAIL reset_u4: got busy=%b done=%b sum=%h cout=%b, want all 0", busy4, done4, sum4, cout4);
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++;
    if ({ovf8, ovf4} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ovf: got %b%b, want 00", ovf8, ovf4);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    go8(8'h5A, 8'h3C, 1'b0);
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept: got busy=%b done=%b, want busy=1 done=0", busy8, done8);
    end
    for (int i = 1; i < 8; i++) begin
      @(posedge clk); #1;
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h00) begin
        errors++;
        $display("FAIL basic_run%0d: got busy=%b done=%b sum=%h, want 1 0 00", i, busy8, done8, sum8);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || sum8 !== 8'h96 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b busy=%b sum=%h cout=%b, want 1 0 96 0", done8, busy8, sum8, cout8);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h96) begin
      errors++;
      $display("FAIL basic_after: got done=%b busy=%b sum=%h, want 0 0 96", done8, busy8, sum8);
    end
  endtask

  task automatic test_carry;
    int cyc;
    go8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'h00 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL carry_wrap: got cyc=%0d sum=%h cout=%b, want 8 00 1", cyc, sum8, cout8);
    end
    @(posedge clk); #1;
    go8(8'hFF, 8'hFF, 1'b1);
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'hFF || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL carry_max: got cyc=%0d sum=%h cout=%b, want 8 ff 1", cyc, sum8, cout8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4;
    int cyc;
    logic [4:0] want;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          wait_done4(cyc);
          want = 5'(ia + ib + ic);
          checks++;
          if (cyc !== 2 || {cout4, sum4} !== want) begin
            errors++;
            $display("FAIL exh4 a=%0d b=%0d cin=%0d: got cyc=%0d {cout,sum}=%h, want 2 %h", ia, ib, ic, cyc, {cout4, sum4}, want);
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    go8(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("FAIL ignore_busy: got busy=%b, want 1", busy8);
    end
    wait_done8(cyc);
    checks++;
    if (cyc !== 6 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start: got cyc=%0d sum=%h cout=%b, want 6 30 0", cyc, sum8, cout8);
    end
    // start held during the DONE cycle: next op begins with no idle gap.
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h30) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b done=%b sum=%h, want 1 0 30", busy8, done8, sum8);
    end
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'h02 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result: got cyc=%0d sum=%h cout=%b, want 8 02 0", cyc, sum8, cout8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    int seen;
    go8(8'h55, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b done=%b sum=%h cout=%b, want all 0", busy8, done8, sum8, cout8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d active cycles, want 0", seen);
    end
    go8(8'h21, 8'h12, 1'b1);
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'h34 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: got cyc=%0d sum=%h cout=%b, want 8 34 0", cyc, sum8, cout8);
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf;
    int cyc;
    go8(8'h7F, 8'h01, 1'b0);
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'h80 || ovf8 !== 1'b1 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pos: got cyc=%0d sum=%h ovf=%b cout=%b, want 8 80 1 0", cyc, sum8, ovf8, cout8);
    end
    @(posedge clk); #1;
    go8(8'h80, 8'h80, 1'b0);
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'h00 || ovf8 !== 1'b1 || cout8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: got cyc=%0d sum=%h ovf=%b cout=%b, want 8 00 1 1", cyc, sum8, ovf8, cout8);
    end
    @(posedge clk); #1;
    go8(8'h01, 8'h01, 1'b0);
    wait_done8(cyc);
    checks++;
    if (cyc !== 8 || sum8 !== 8'h02 || ovf8 !== 1'b0 || cout8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none: got cyc=%0d sum=%h ovf=%b cout=%b, want 8 02 0 0", cyc, sum8, ovf8, cout8);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_exhaustive4();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
